// File: rtl/cpu_nios2_qsys_0_mulx_seq.sv
// Sequential 32x32 extended multiplier: four 16x16 partial products are pushed through
// one registered multiplier, then the high word is sign-corrected for mulxsu/mulxss.
module cpu_nios2_qsys_0_mulx_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MUL2,
    S_MUL3,
    S_DRAIN,
    S_CORR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] pp_q, pp_d;
  logic [31:0] result_q, result_d;
  logic [15:0] mul_a, mul_b;
  logic [31:0] hi_corr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 2'b00;
      acc_q    <= 64'h0;
      pp_q     <= 32'h0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      pp_q     <= pp_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    mul_a    = 16'h0;
    mul_b    = 16'h0;

    // Two's-complement fix-up of the unsigned high word: a signed operand with its
    // top bit set contributes -2^32 times the other operand.
    hi_corr = acc_q[63:32];
    if (op_q[1] && a_q[31])
      hi_corr = hi_corr - b_q;
    if ((op_q == 2'b11) && b_q[31])
      hi_corr = hi_corr - a_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          op_d    = op;
          acc_d   = 64'h0;
          state_d = S_MUL0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL0: begin
        mul_a   = a_q[15:0];
        mul_b   = b_q[15:0];
        state_d = S_MUL1;
      end
      S_MUL1: begin
        mul_a   = a_q[31:16];
        mul_b   = b_q[15:0];
        acc_d   = acc_q + {32'h0, pp_q};
        state_d = S_MUL2;
      end
      S_MUL2: begin
        mul_a   = a_q[15:0];
        mul_b   = b_q[31:16];
        acc_d   = acc_q + ({32'h0, pp_q} << 16);
        state_d = S_MUL3;
      end
      S_MUL3: begin
        mul_a   = a_q[31:16];
        mul_b   = b_q[31:16];
        acc_d   = acc_q + ({32'h0, pp_q} << 16);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d   = acc_q + {pp_q, 32'h0};
        state_d = S_CORR;
      end
      S_CORR: begin
        result_d = (op_q == 2'b00) ? acc_q[31:0] : hi_corr;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single shared multiplier; its output lands in pp_q one cycle after issue.
  assign pp_d = {16'h0, mul_a} * {16'h0, mul_b};

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_cpu_nios2_qsys_0_mulx_seq.sv
// Bench for the sequential extended multiplier: directed corner cases, handshake and
// reset behaviour, then random operations against a plain 64-bit arithmetic model.
module tb_cpu_nios2_qsys_0_mulx_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src1 = 32'h0;
  logic [31:0] src2 = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_nios2_qsys_0_mulx_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Product of the operands as the ISA defines them, taken modulo 2^64.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = o[1]         ? {{32{a[31]}}, a} : {32'h0, a};
    eb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called on a falling edge with the DUT idle; returns on the falling edge after done.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit noise);
    int cyc;
    bit busy_ok, stable_ok;
    logic [31:0] prev;
    prev  = result;
    start = 1'b1;
    op    = o;
    src1  = a;
    src2  = b;
    @(negedge clk);
    cyc       = 1;
    start     = 1'b0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    if (noise) begin
      src1 = $urandom;
      src2 = $urandom;
      op   = 2'($urandom_range(0, 3));
    end
    while (!done && cyc < 20) begin
      if (!busy) busy_ok = 1'b0;
      if (result !== prev) stable_ok = 1'b0;
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    $display("op=%0d a=%h b=%h result=%h exp=%h done_cycle=%0d [%s]", o, a, b, result, exp, cyc, tag);
    check_eq({tag, " latency"}, 64'(cyc), 64'd7);
    check_eq({tag, " result"}, {32'h0, result}, {32'h0, exp});
    check_eq({tag, " busy/stable"}, {62'h0, busy_ok, stable_ok}, 64'h3);
    check_eq({tag, " busy at done"}, {63'h0, busy}, 64'h0);
    @(negedge clk);
    check_eq({tag, " after done"}, {62'h0, busy, done}, 64'h0);
  endtask

  initial begin
    int cyc;
    bit saw_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [31:0] edges [4];
    logic [1:0]  d_op  [9];
    logic [31:0] d_a   [9];
    logic [31:0] d_b   [9];
    logic [31:0] d_exp [9];

    edges = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    d_op  = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1};
    d_a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    d_b   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'h80000000, 32'h80000000, 32'h80000000, 32'h00000002, 32'h00000002};
    d_exp = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'h00000001,
              32'h40000000, 32'h40000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000001};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("reset outputs", {30'h0, busy, done, result}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed extremes, with start noise and operand scrambling on alternate runs
    for (int i = 0; i < 9; i++)
      do_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], d_exp[i], (i % 2) == 1);

    // Back-to-back with start held high; operands change after each acceptance
    start = 1'b1; op = 2'd2; src1 = 32'h80000000; src2 = 32'h00000002;
    @(negedge clk);
    cyc = 1;
    op = 2'd1; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
    while (!done && cyc < 20) begin @(negedge clk); cyc++; end
    $display("b2b first: result=%h done_cycle=%0d", result, cyc);
    check_eq("b2b first cycle", 64'(cyc), 64'd7);
    check_eq("b2b first result", {32'h0, result}, 64'hFFFFFFFF);
    @(negedge clk);
    cyc++;
    start = 1'b0; op = 2'd3; src1 = 32'h12345678; src2 = 32'h9ABCDEF0;
    while (!done && cyc < 30) begin @(negedge clk); cyc++; end
    $display("b2b second: result=%h done_cycle=%0d", result, cyc);
    check_eq("b2b second cycle", 64'(cyc), 64'd14);
    check_eq("b2b second result", {32'h0, result}, 64'hFFFFFFFE);
    @(negedge clk);
    check_eq("b2b idle", {62'h0, busy, done}, 64'h0);

    // Reset in the middle of an operation
    start = 1'b1; op = 2'd1; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    $display("mid-op reset: busy=%b done=%b result=%h", busy, done, result);
    check_eq("midop reset", {30'h0, busy, done, result}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check_eq("no done after reset", {63'h0, saw_done}, 64'h0);
    do_op("post-reset", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);

    // Randomised operations against the reference model
    for (int i = 0; i < 2000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      do_op($sformatf("rnd%0d", i), ro, ra, rb, ref_model(ro, ra, rb), (i % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
